// File: rtl/cam_ddr_pkg.sv
// Shared types and elaboration helpers for the DDR pixel gearbox.
// Pure package: no logic, no latency, no flow control.
package cam_ddr_pkg;

  typedef enum logic {
    UNP_EMPTY  = 1'b0,
    UNP_LOADED = 1'b1
  } unp_state_t;

  function automatic int ratio_of(input int word_w, input int pix_w);
    return (pix_w > 0) ? (word_w / pix_w) : 0;
  endfunction

  // Smallest n with 2**n >= ratio; equals log2 when ratio is a power of two.
  function automatic int ratio_log2(input int ratio);
    int n;
    n = 0;
    while ((n < 31) && ((1 << n) < ratio)) n++;
    return n;
  endfunction

endpackage

// File: rtl/pix_unpacker.sv
// DDR word to pixel stream unpacker; p_valid/p_data follow p_req by one cycle.
// r_ready is combinational: high when EMPTY or when the last slot is requested.
module pix_unpacker
  import cam_ddr_pkg::*;
#(
  parameter int              PIX_W     = 16,
  parameter int              WORD_W    = 256,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [PIX_W-1:0] PAD      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              r_valid,
  input  logic [WORD_W-1:0] r_data,
  output logic              r_ready,
  input  logic              p_restart,
  input  logic              p_req,
  output logic              p_valid,
  output logic [PIX_W-1:0]  p_data,
  output logic              err_underrun
);

  localparam int RATIO = ratio_of(WORD_W, PIX_W);
  localparam int CW    = ratio_log2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  unp_state_t        state, state_nx;
  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     ui;
  logic [PIX_W-1:0]  slot_v;
  logic              last_slot, take, pop, underrun;
  int                shamt;

  assign last_slot = (ui == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNP_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (p_restart) begin
      state_nx = UNP_EMPTY;
    end else begin
      case (state)
        UNP_EMPTY:  if (take) state_nx = UNP_LOADED;
        UNP_LOADED: if (pop && last_slot) state_nx = take ? UNP_LOADED : UNP_EMPTY;
        default:    state_nx = UNP_EMPTY;
      endcase
    end
  end

  // Restart suppresses every handshake so a simultaneous word or request is dropped.
  always_comb begin
    r_ready  = 1'b0;
    pop      = 1'b0;
    underrun = 1'b0;
    take     = 1'b0;
    if (run && !p_restart) begin
      case (state)
        UNP_EMPTY: begin
          r_ready  = 1'b1;
          underrun = p_req;
        end
        UNP_LOADED: begin
          pop     = p_req;
          r_ready = p_req && last_slot;
        end
        default: ;
      endcase
      take = r_ready && r_valid;
    end
  end

  always_comb begin
    shamt  = MSB_FIRST ? (RATIO - 1 - int'(ui)) * PIX_W : int'(ui) * PIX_W;
    slot_v = PIX_W'(word_q >> shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= '0;
      ui           <= '0;
      p_valid      <= 1'b0;
      p_data       <= '0;
      err_underrun <= 1'b0;
    end else begin
      p_valid <= pop || underrun;
      if (p_restart) begin
        ui           <= '0;
        err_underrun <= 1'b0;
      end else begin
        if (underrun) err_underrun <= 1'b1;
        if (pop) begin
          p_data <= slot_v;
          ui     <= last_slot ? '0 : ui + 1'b1;
        end else if (underrun) begin
          p_data <= PAD;
        end
        if (take) begin
          word_q <= r_data;
          ui     <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_pix_gearbox.sv
// Pixel to DDR word packer plus word to pixel unpacker; packed word appears the cycle after its last pixel.
// in_ready = !w_valid || w_ready, so a held word stalls packing while back-to-back words flow at full rate.
module ddr_pix_gearbox
  import cam_ddr_pkg::*;
#(
  parameter int               PIX_W     = 16,
  parameter int               WORD_W    = 256,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [PIX_W-1:0] PAD       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pix,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              in_ready,
  output logic              w_valid,
  output logic [WORD_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready,
  input  logic              r_valid,
  input  logic [WORD_W-1:0] r_data,
  output logic              r_ready,
  input  logic              p_restart,
  input  logic              p_req,
  output logic              p_valid,
  output logic [PIX_W-1:0]  p_data,
  output logic              err_partial,
  output logic              err_underrun,
  output logic [15:0]       word_cnt
);

  localparam int RATIO = ratio_of(WORD_W, PIX_W);
  localparam int CW    = ratio_log2(RATIO);
  localparam logic [CW-1:0]     LAST     = CW'(RATIO - 1);
  localparam logic [WORD_W-1:0] LOW_MASK = WORD_W'({PIX_W{1'b1}});

  if ((RATIO * PIX_W != WORD_W) || (RATIO < 2) || ((1 << CW) != RATIO)) begin : g_bad_ratio
    $error("ddr_pix_gearbox: WORD_W/PIX_W must be a power of two >= 2");
  end

  logic              run;
  logic [CW-1:0]     pcnt, idx;
  logic [WORD_W-1:0] slots_q, slots_nx, word_nx;
  logic [PIX_W-1:0]  slot_v;
  logic              accept, drop_partial, flush;
  int                k_sel, ws;

  assign in_ready     = run && (!w_valid || w_ready);
  assign accept       = in_valid && in_ready;
  assign drop_partial = in_sof && (pcnt != '0);
  assign idx          = drop_partial ? '0 : pcnt;
  assign flush        = (idx == LAST) || in_eof;
  assign ws           = int'(idx) * PIX_W;
  assign slots_nx     = (slots_q & ~(LOW_MASK << ws)) | (WORD_W'(in_pix) << ws);

  // Shift slots in so that slot 0 ends up at the MSB or LSB end as configured.
  always_comb begin
    word_nx = '0;
    slot_v  = '0;
    k_sel   = 0;
    for (int j = 0; j < RATIO; j++) begin
      k_sel = MSB_FIRST ? j : (RATIO - 1 - j);
      if (k_sel < int'(idx))       slot_v = PIX_W'(slots_q >> (k_sel * PIX_W));
      else if (k_sel == int'(idx)) slot_v = in_pix;
      else                         slot_v = PAD;
      word_nx = {word_nx[WORD_W-PIX_W-1:0], slot_v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      pcnt        <= '0;
      slots_q     <= '0;
      w_valid     <= 1'b0;
      w_data      <= '0;
      w_last      <= 1'b0;
      err_partial <= 1'b0;
      word_cnt    <= '0;
    end else begin
      run         <= 1'b1;
      err_partial <= accept && drop_partial;
      if (w_valid && w_ready) begin
        w_valid  <= 1'b0;
        word_cnt <= word_cnt + 16'd1;
      end
      if (accept) begin
        if (flush) begin
          w_valid <= 1'b1;
          w_data  <= word_nx;
          w_last  <= in_eof;
          pcnt    <= '0;
        end else begin
          slots_q <= slots_nx;
          pcnt    <= idx + 1'b1;
        end
      end
    end
  end

  pix_unpacker #(
    .PIX_W     (PIX_W),
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST),
    .PAD       (PAD)
  ) u_unpack (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .r_valid      (r_valid),
    .r_data       (r_data),
    .r_ready      (r_ready),
    .p_restart    (p_restart),
    .p_req        (p_req),
    .p_valid      (p_valid),
    .p_data       (p_data),
    .err_underrun (err_underrun)
  );

endmodule

// File: tb/tb_ddr_pix_gearbox.sv
// Directed bench for ddr_pix_gearbox at default widths with PAD = 0xABCD.
module tb_ddr_pix_gearbox;

  localparam logic [15:0] PADV = 16'hABCD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, w_ready = 1'b0;
  logic [15:0]  in_pix = '0;
  logic         r_valid = 1'b0, p_restart = 1'b0, p_req = 1'b0;
  logic [255:0] r_data = '0;
  logic         in_ready, w_valid, w_last, r_ready, p_valid, err_partial, err_underrun;
  logic [255:0] w_data;
  logic [15:0]  p_data, word_cnt;

  int checks = 0;
  int errors = 0;

  ddr_pix_gearbox #(.PIX_W(16), .WORD_W(256), .MSB_FIRST(1'b1), .PAD(PADV)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pix(in_pix), .in_sof(in_sof), .in_eof(in_eof), .in_ready(in_ready),
    .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .p_restart(p_restart), .p_req(p_req), .p_valid(p_valid), .p_data(p_data),
    .err_partial(err_partial), .err_underrun(err_underrun), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: captures accepted words, err_partial cycles and emitted pixels.
  logic [255:0] wd [0:15];
  logic         wl [0:15];
  logic [15:0]  pd [0:63];
  int           pc [0:63];
  int nw = 0, np = 0, epc = 0, cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (w_valid && w_ready && nw < 16) begin
      wd[nw] = w_data;
      wl[nw] = w_last;
      nw++;
    end
    if (err_partial) epc++;
    if (p_valid && np < 64) begin
      pd[np] = p_data;
      pc[np] = cyc;
      np++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish expected one");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] pix;
    logic        sof;
    logic        eof;
  } pvec_t;

  typedef struct {
    int          widx;
    int          slot;
    logic [15:0] val;
    logic        last;
  } wchk_t;

  pvec_t pv [60];
  wchk_t wc [12];

  function automatic logic [15:0] slot(input logic [255:0] w, input int k);
    return 16'(w >> (240 - 16 * k));
  endfunction

  function automatic logic [255:0] make_word(input logic [15:0] base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w = {w[239:0], 16'(base + k)};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] px, input logic s, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pix = px; in_sof = s; in_eof = e;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: pixel 0x%0h got in_ready=0 expected 1 within 50 cycles", px);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [255:0] wa, wb;

  initial begin
    // Pack stream: 32 plain pixels, a 5-pixel eof frame, then 7 pixels cut short by a new sof.
    for (int i = 0; i < 32; i++) pv[i] = '{16'(i + 1), 1'b0, 1'b0};
    for (int i = 0; i < 5; i++)  pv[32 + i] = '{16'(16'h0101 + i), i == 0, i == 4};
    for (int i = 0; i < 7; i++)  pv[37 + i] = '{16'(16'h0201 + i), i == 0, 1'b0};
    for (int i = 0; i < 16; i++) pv[44 + i] = '{16'(16'h0301 + i), i == 0, 1'b0};

    wc[0]  = '{0, 0,  16'h0001, 1'b0};
    wc[1]  = '{0, 7,  16'h0008, 1'b0};
    wc[2]  = '{0, 15, 16'h0010, 1'b0};
    wc[3]  = '{1, 0,  16'h0011, 1'b0};
    wc[4]  = '{1, 15, 16'h0020, 1'b0};
    wc[5]  = '{2, 0,  16'h0101, 1'b1};
    wc[6]  = '{2, 4,  16'h0105, 1'b1};
    wc[7]  = '{2, 5,  PADV,     1'b1};
    wc[8]  = '{2, 15, PADV,     1'b1};
    wc[9]  = '{3, 0,  16'h0301, 1'b0};
    wc[10] = '{3, 1,  16'h0302, 1'b0};
    wc[11] = '{3, 15, 16'h0310, 1'b0};

    wa = make_word(16'h0501);
    wb = make_word(16'h0601);

    // Reset state
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_data", 32'(w_data[31:0] | w_data[255:224]), 0);
    chk("rst_w_last", w_last, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_err_partial", err_partial, 0);
    chk("rst_err_underrun", err_underrun, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rst = 1'b0;
    w_ready = 1'b1;
    cycles(1);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_r_ready", r_ready, 1);

    // Table-driven pack stream
    for (int i = 0; i < 60; i++) begin
      send(pv[i].pix, pv[i].sof, pv[i].eof);
      if (i == 31 || i == 36) begin
        idle();
        cycles(2);
        chk($sformatf("word_cnt_after_vec%0d", i), word_cnt, (i == 31) ? 2 : 3);
        chk($sformatf("err_partial_quiet_vec%0d", i), epc, 0);
      end
    end
    idle();
    cycles(3);
    chk("pack_word_count", nw, 4);
    chk("pack_word_cnt", word_cnt, 4);
    chk("err_partial_cycles", epc, 1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("word%0d_slot%0d", wc[c].widx, wc[c].slot), slot(wd[wc[c].widx], wc[c].slot), wc[c].val);
      chk($sformatf("word%0d_last", wc[c].widx), wl[wc[c].widx], wc[c].last);
    end

    // Backpressure: hold a full word while the next pixel is offered
    w_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(16'(16'h0401 + k), 1'b0, 1'b0);
    @(negedge clk);
    in_pix = 16'h0411;
    #1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      chk($sformatf("bp_in_ready_c%0d", j), in_ready, 0);
      chk($sformatf("bp_w_valid_c%0d", j), w_valid, 1);
      chk($sformatf("bp_w_data_c%0d", j), slot(w_data, 0), 16'h0401);
    end
    in_valid = 1'b0;
    w_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(16'(16'h0411 + k), 1'b0, 1'b0);
    idle();
    cycles(3);
    chk("bp_word_count", nw, 6);
    chk("bp_word4_slot0", slot(wd[4], 0), 16'h0401);
    chk("bp_word4_slot15", slot(wd[4], 15), 16'h0410);
    chk("bp_word5_slot0", slot(wd[5], 0), 16'h0411);
    chk("bp_word5_slot15", slot(wd[5], 15), 16'h0420);
    chk("bp_word_cnt", word_cnt, 6);

    // Reset mid-word drops the partial pixels
    for (int k = 0; k < 5; k++) send(16'(16'h0701 + k), 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_word_cnt", word_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    for (int k = 0; k < 16; k++) send(16'(16'h0801 + k), 1'b0, 1'b0);
    idle();
    cycles(3);
    chk("midrst_word_count", nw, 7);
    chk("midrst_slot0", slot(wd[6], 0), 16'h0801);
    chk("midrst_slot15", slot(wd[6], 15), 16'h0810);
    chk("midrst_word_cnt", word_cnt, 1);

    // Unpack two back-to-back words with p_req held for 32 cycles
    @(negedge clk);
    r_valid = 1'b1; r_data = wa;
    #1;
    chk("unp_empty_r_ready", r_ready, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) r_data = wb;
      if (i == 16) r_valid = 1'b0;
      p_req = 1'b1;
      #1;
      chk($sformatf("unp_r_ready_req%0d", i), r_ready, (i == 15 || i == 31));
    end
    @(negedge clk);
    p_req = 1'b0;
    #1;
    chk("unp_back_empty_r_ready", r_ready, 1);
    cycles(2);
    chk("unp_pixel_count", np, 32);
    chk("unp_no_gap", pc[31] - pc[0], 31);
    for (int i = 0; i < 32; i++)
      chk($sformatf("unp_pix%0d", i), pd[i], (i < 16) ? 16'(16'h0501 + i) : 16'(16'h0601 + i - 16));

    // Underrun, sticky flag, restart priority
    @(negedge clk); p_req = 1'b1;
    @(negedge clk); p_req = 1'b0;
    #1;
    chk("udr_p_valid", p_valid, 1);
    chk("udr_p_data", p_data, PADV);
    chk("udr_err_underrun", err_underrun, 1);
    cycles(1);
    chk("udr_p_valid_drop", p_valid, 0);
    chk("udr_p_data_hold", p_data, PADV);
    chk("udr_sticky", err_underrun, 1);
    @(negedge clk);
    p_restart = 1'b1; p_req = 1'b1; r_valid = 1'b1; r_data = wa;
    #1;
    chk("restart_r_ready", r_ready, 0);
    @(negedge clk);
    p_restart = 1'b0; p_req = 1'b0; r_valid = 1'b0;
    #1;
    chk("restart_p_valid", p_valid, 0);
    chk("restart_clears_underrun", err_underrun, 0);
    chk("restart_r_ready_after", r_ready, 1);
    @(negedge clk); p_req = 1'b1;
    @(negedge clk); p_req = 1'b0;
    #1;
    chk("restart_dropped_word", p_data, PADV);
    chk("restart_then_underrun", err_underrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_pix_gearbox.md
DDR_PIX_GEARBOX -- requirements
Module: ddr_pix_gearbox

Interface
REQ-001 SHALL have parameter PIX_W, default 16: pixel width in bits.
REQ-002 SHALL have parameter WORD_W, default 256: DDR user word width; WORD_W/PIX_W = RATIO, a power of two, at least 2; any other value fails elaboration.
REQ-003 SHALL have parameter MSB_FIRST, default 1: when 1, the first pixel goes in word[WORD_W-1 -: PIX_W]; when 0, it goes in word[PIX_W-1:0].
REQ-004 SHALL have parameter PAD, default 0: PIX_W-bit fill value for unused slots of a flushed partial word.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have pack-side ports: in_valid (in, 1), in_pix (in, PIX_W), in_sof (in, 1, first pixel of frame), in_eof (in, 1, last pixel of frame), in_ready (out, 1).
REQ-008 SHALL have word-out ports: w_valid (out, 1), w_data (out, WORD_W), w_last (out, 1, word holds the eof pixel), w_ready (in, 1).
REQ-009 SHALL have word-in ports: r_valid (in, 1), r_data (in, WORD_W), r_ready (out, 1).
REQ-010 SHALL have pixel-out ports: p_restart (in, 1), p_req (in, 1), p_valid (out, 1), p_data (out, PIX_W).
REQ-011 SHALL have status ports: err_partial (out, 1, pulse), err_underrun (out, 1, sticky), word_cnt (out, 16, packed words sent, wraps).

Function
REQ-012 SHALL transfer a pixel when in_valid and in_ready are both high; in_ready = !w_valid || w_ready.
REQ-013 SHALL place accepted pixels into a shift/slot register in arrival order per MSB_FIRST, with slot counter pcnt counting 0..RATIO-1.
REQ-014 SHALL load the output register (w_valid=1 on the next cycle) when the pixel in slot RATIO-1 is accepted, then reset pcnt to 0.
REQ-015 SHALL, when a pixel with in_eof is accepted at pcnt<RATIO-1, fill the remaining slots with PAD, load the word with w_last=1, and reset pcnt to 0.
REQ-016 SHALL, when a pixel with in_sof is accepted while pcnt!=0, discard the partial word, pulse err_partial for 1 cycle, and place the sof pixel in slot 0.
REQ-017 SHALL treat a pixel with both in_sof and in_eof as a one-pixel frame: err_partial rule first, then the flush rule.
REQ-018 SHALL hold w_valid, w_data and w_last stable until w_ready; a new word may load in the same cycle the old one is taken (no bubble, full throughput).
REQ-019 SHALL increment word_cnt by 1 on each w_valid && w_ready, wrapping from 0xFFFF to 0.
REQ-020 SHALL run the unpack path as a 2-state FSM: EMPTY and LOADED.
REQ-021 In EMPTY, the unpack path SHALL drive r_ready=1; r_valid moves it to LOADED with the word latched and index ui=0.
REQ-022 In LOADED, each p_req SHALL output slot ui (MSB_FIRST order) on p_data with p_valid=1 exactly one cycle later, then increment ui.
REQ-023 SHALL, on a p_req at ui=RATIO-1, drive r_ready=1 combinationally that cycle: if r_valid, latch the next word with ui=0 and stay LOADED (gapless); otherwise go to EMPTY.
REQ-024 SHALL, on p_req in EMPTY, set err_underrun, drive p_valid=1 with p_data=PAD one cycle later, and leave ui unchanged.
REQ-025 SHALL, on p_restart, go to EMPTY and set ui=0; p_restart wins over a simultaneous p_req or r_valid, and no p_valid results.
REQ-026 SHALL keep p_data holding its last value when p_valid=0.

Reset
REQ-027 While rst is high, SHALL force: in_ready=0, w_valid=0, w_data=0, w_last=0, r_ready=0, p_valid=0, p_data=0, err_partial=0, err_underrun=0, word_cnt=0, pcnt=0, ui=0, FSM=EMPTY.
REQ-028 SHALL, after rst deasserts, drive in_ready=1 and r_ready=1 from the next clock edge; reset mid-word discards all partial data.
REQ-029 SHALL clear err_underrun only by rst or p_restart.

Structure
REQ-030 SHALL place the unpack FSM state enum and a RATIO/log2 helper function in shared package cam_ddr_pkg.
REQ-031 SHALL implement the unpack path as sub-module pix_unpacker; the pack path stays in the top module.

Verification
REQ-032 SHALL check 32 consecutive pixels 0x0001..0x0020 at default parameters, with w_ready=1 -> 2 words; word0[255:240]=0x0001 and word0[15:0]=0x0010; w_last=0; word_cnt=2.
REQ-033 SHALL check a 5-pixel frame with eof on pixel 5 and PAD=0xABCD -> 1 word with w_last=1, slots 5..15 = 0xABCD.
REQ-034 SHALL check in_sof after 7 pixels -> err_partial pulses 1 cycle, and the next word starts with the sof pixel.
REQ-035 SHALL check w_ready held low for 3 cycles with a full word pending and a second word completing -> in_ready=0, no data loss, words emitted in order.
REQ-036 SHALL check two back-to-back r_data words with p_req held high for 32 cycles -> 32 p_valid pixels with no gap, and r_ready pulses at ui=15.
REQ-037 SHALL check p_req in EMPTY -> p_data=PAD and err_underrun=1; then p_restart clears it.
